// File: rtl/inv_tree_capture_monitor_if.sv
// Bundle of the control inputs, raw tree outputs and the monitor results.
// The harness is the master; the capture monitor is the slave.
interface inv_tree_capture_monitor_if #(
  parameter int N_OUT = 4,
  parameter int CNT_W = 16
);
  logic                   en;
  logic                   clr;
  logic [N_OUT-1:0]       dout_in;
  logic [N_OUT*CNT_W-1:0] trans_cnt;
  logic [7:0]             max_skew;
  logic                   event_done;
  logic                   mismatch;
  logic                   skew_err;
  logic                   glitch_err;
  logic                   busy;

  modport master (
    output en, clr, dout_in,
    input  trans_cnt, max_skew, event_done, mismatch, skew_err, glitch_err, busy
  );
  modport slave (
    input  en, clr, dout_in,
    output trans_cnt, max_skew, event_done, mismatch, skew_err, glitch_err, busy
  );
endinterface

// File: rtl/inv_tree_capture_monitor.sv
// Capture monitor for the inverter fan-out tree: synchronizes the tree outputs,
// counts their edges and measures first-to-last edge skew of each propagated event.
module inv_tree_capture_monitor #(
  parameter int N_OUT       = 4,
  parameter int CNT_W       = 16,
  parameter int WIN         = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  inv_tree_capture_monitor_if.slave     mon
);
  localparam logic [7:0]       SKEW_LAST = 8'(WIN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic {S_IDLE, S_COLLECT} state_t;

  logic [SYNC_STAGES-1:0][N_OUT-1:0] r_sync;
  logic [N_OUT-1:0]                  r_prev;
  logic [N_OUT-1:0]                  r_edge;

  // Synchronizer and edge detect run independently of en so the edge
  // history is always current when monitoring is enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= '0;
      r_edge <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], mon.dout_in};
      r_prev <= r_sync[SYNC_STAGES-1];
      r_edge <= r_sync[SYNC_STAGES-1] ^ r_prev;
    end
  end

  logic [N_OUT-1:0][CNT_W-1:0] w_cnt;

  for (genvar g = 0; g < N_OUT; g++) begin : g_lane
    logic [CNT_W-1:0] r_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        r_cnt <= '0;
      else if (mon.clr)
        r_cnt <= '0;
      else if (mon.en && r_edge[g] && r_cnt != CNT_MAX)
        r_cnt <= r_cnt + 1'b1;
    end
    assign w_cnt[g] = r_cnt;
  end

  state_t           r_state;
  logic [7:0]       r_skew;
  logic [7:0]       r_max;
  logic [N_OUT-1:0] r_seen;
  logic             r_done;
  logic             r_mis;
  logic             r_serr;
  logic             r_gerr;
  logic             r_busy;

  logic [7:0]       w_skew_nx;
  logic [N_OUT-1:0] w_seen_nx;
  logic             w_all;
  logic             w_glitch;
  logic             w_active;

  assign w_skew_nx = r_skew + 8'd1;
  assign w_seen_nx = r_seen | r_edge;
  assign w_all     = &w_seen_nx;
  assign w_glitch  = |(r_edge & r_seen);
  assign w_active  = (r_state == S_COLLECT) && mon.en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_skew  <= '0;
      r_seen  <= '0;
      r_max   <= '0;
      r_done  <= 1'b0;
      r_mis   <= 1'b0;
      r_serr  <= 1'b0;
      r_gerr  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_mis  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (mon.en && |r_edge) begin
            r_skew <= '0;
            r_seen <= r_edge;
            // All outputs moving together is a complete zero-skew event.
            if (&r_edge) begin
              r_done <= 1'b1;
            end else begin
              r_state <= S_COLLECT;
              r_busy  <= 1'b1;
            end
          end
        end
        S_COLLECT: begin
          if (!mon.en) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_skew <= w_skew_nx;
            r_seen <= w_seen_nx;
            if (w_all) begin
              r_done  <= 1'b1;
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else if (w_skew_nx == SKEW_LAST) begin
              r_mis   <= 1'b1;
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase

      // Statistics and sticky flags; clear wins over a same-cycle update.
      if (mon.clr) begin
        r_max  <= '0;
        r_serr <= 1'b0;
        r_gerr <= 1'b0;
      end else if (w_active) begin
        if (w_glitch)
          r_gerr <= 1'b1;
        if (w_all && w_skew_nx > r_max)
          r_max <= w_skew_nx;
        if (!w_all && w_skew_nx == SKEW_LAST)
          r_serr <= 1'b1;
      end
    end
  end

  assign mon.trans_cnt  = w_cnt;
  assign mon.max_skew   = r_max;
  assign mon.event_done = r_done;
  assign mon.mismatch   = r_mis;
  assign mon.skew_err   = r_serr;
  assign mon.glitch_err = r_gerr;
  assign mon.busy       = r_busy;
endmodule

// File: tb/tb_inv_tree_capture_monitor.sv
// Scoreboard bench for the tree capture monitor: each stimulus pushes the pulse it
// should produce (kind, cycle, skew); a negedge monitor pops and compares.
module tb_inv_tree_capture_monitor;
  localparam int N  = 4;
  localparam int CW = 4;
  localparam int WN = 8;
  localparam int SS = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  inv_tree_capture_monitor_if #(.N_OUT(N), .CNT_W(CW)) mif();

  inv_tree_capture_monitor #(.N_OUT(N), .CNT_W(CW), .WIN(WN), .SYNC_STAGES(SS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mon   (mif)
  );

  typedef struct {
    bit mis;
    int at;
    int skew;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   exp_cnt[N];
  int   exp_max = 0;
  int   busy_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (mif.busy) busy_seen++;
      if (mif.event_done || mif.mismatch) begin
        if (sb.size() == 0) begin
          chk("unexpected_pulse", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          chk("pulse_kind", 64'(mif.mismatch), 64'(mon_e.mis));
          chk("pulse_cycle", cyc, mon_e.at);
          if (!mon_e.mis) begin
            if (mon_e.skew > exp_max) exp_max = mon_e.skew;
            chk("max_skew", mif.max_skew, exp_max);
          end
        end
      end
    end
  end

  task automatic tog(input logic [N-1:0] m, output int p);
    @(negedge clk);
    mif.dout_in = mif.dout_in ^ m;
    p = cyc;
    for (int i = 0; i < N; i++)
      if (m[i] && mif.en && exp_cnt[i] < (2**CW) - 1) exp_cnt[i]++;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input bit mis, input int at, input int skew);
    exp_t e;
    e.mis = mis; e.at = at; e.skew = skew;
    sb.push_back(e);
  endtask

  task automatic chk_cnts(input string tag);
    for (int i = 0; i < N; i++)
      chk($sformatf("%s_cnt%0d", tag, i), mif.trans_cnt[i*CW +: CW], exp_cnt[i]);
  endtask

  task automatic chk_flags(input string tag, input bit serr, input bit gerr);
    chk({tag, "_skew_err"}, mif.skew_err, serr);
    chk({tag, "_glitch_err"}, mif.glitch_err, gerr);
  endtask

  task automatic do_clr();
    @(negedge clk);
    mif.clr = 1'b1;
    @(negedge clk);
    mif.clr = 1'b0;
    for (int i = 0; i < N; i++) exp_cnt[i] = 0;
    exp_max = 0;
  endtask

  int p, q;

  initial begin
    mif.en = 1'b0;
    mif.clr = 1'b0;
    mif.dout_in = '0;
    for (int i = 0; i < N; i++) exp_cnt[i] = 0;
    idle(3);
    chk("rst_busy", mif.busy, 0);
    chk("rst_max_skew", mif.max_skew, 0);
    rst_n = 1'b1;
    mif.en = 1'b1;
    idle(4);
    chk_cnts("reset");
    chk_flags("reset", 0, 0);

    // All four outputs in one cycle: zero-skew event, busy never seen
    busy_seen = 0;
    tog(4'hF, p);
    push(0, p + 4, 0);
    idle(8);
    chk("t2_busy_cycles", busy_seen, 0);
    chk_cnts("t2");

    // Staggered edges at 0,1,3,5
    tog(4'h1, p);
    push(0, p + 9, 5);
    tog(4'h2, q);
    idle(1);
    tog(4'h4, q);
    idle(1);
    tog(4'h8, q);
    idle(10);
    chk_flags("t3", 0, 0);
    chk("t3_max_skew", mif.max_skew, 5);
    chk_cnts("t3");

    // dout4 silent: window expiry
    do_clr();
    tog(4'h7, p);
    push(1, p + 11, 0);
    idle(14);
    chk_flags("t4", 1, 0);
    chk_cnts("t4");

    // dout2 toggles twice inside one event
    do_clr();
    tog(4'h1, p);
    push(0, p + 7, 3);
    tog(4'h2, q);
    tog(4'h2, q);
    tog(4'hC, q);
    idle(10);
    chk_flags("t5", 0, 1);
    chk_cnts("t5");

    // en dropped mid-event: abort with no pulse and no error
    do_clr();
    tog(4'h1, p);
    idle(4);
    chk("abort_busy_on", mif.busy, 1);
    mif.en = 1'b0;
    idle(12);
    chk("abort_busy_off", mif.busy, 0);
    chk_flags("abort", 0, 0);
    chk_cnts("abort");
    mif.en = 1'b1;

    // Counter saturation and clear
    do_clr();
    for (int k = 0; k < 20; k++) begin
      tog(4'hF, p);
      push(0, p + 4, 0);
      idle(5);
    end
    idle(4);
    chk_cnts("t6_sat");
    do_clr();
    idle(1);
    chk_cnts("t6_clr");
    chk_flags("t6_clr", 0, 0);
    chk("t6_clr_max_skew", mif.max_skew, 0);

    // Async reset in the middle of an event
    tog(4'h1, p);
    push(0, 0, 0);
    sb.pop_back();
    tog(4'h2, q);
    idle(4);
    chk("t1_busy_before", mif.busy, 1);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) exp_cnt[i] = 0;
    exp_max = 0;
    chk("t1_busy", mif.busy, 0);
    chk("t1_done", mif.event_done, 0);
    chk("t1_mismatch", mif.mismatch, 0);
    chk("t1_max_skew", mif.max_skew, 0);
    chk_flags("t1", 0, 0);
    chk_cnts("t1");
    mif.dout_in = '0;
    idle(3);
    rst_n = 1'b1;
    idle(12);
    chk("t1_idle_after", mif.busy, 0);
    chk_cnts("t1_after");

    chk("sb_left", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
